// File: rtl/uart_tx_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_param
// Brief    : Parameterised UART transmitter with a one-word holding buffer
//            and per-word parity selection.
// Revision : 1.0
// ============================================================================
module uart_tx_param #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    output logic                  DATA_READY,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int c_cnt_w = $clog2(CLKS_PER_BIT);
    localparam int c_idx_w = $clog2(DATA_WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_idx_w-1:0] c_data_last = c_idx_w'(DATA_WIDTH - 1);
    localparam logic [c_idx_w-1:0] c_stop_last = c_idx_w'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 r_state;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [c_idx_w-1:0]     r_idx;
    logic [DATA_WIDTH-1:0]  r_shift;
    logic                   r_par_en;
    logic                   r_par_bit;
    logic                   r_tx;
    logic                   r_busy;

    logic [DATA_WIDTH-1:0]  r_buf_data;
    logic                   r_buf_par_en;
    logic                   r_buf_par_typ;
    logic                   r_buf_full;
    logic                   r_ready;

    logic                   w_bit_end;
    logic                   w_frame_end;
    logic                   w_load;
    logic                   w_accept;

    assign w_bit_end   = (r_cnt == c_cnt_last);
    assign w_frame_end = (r_state == S_STOP) && w_bit_end && (r_idx == c_stop_last);
    // Buffer drains into the shifter from IDLE or straight out of the last stop bit.
    assign w_load      = r_buf_full && ((r_state == S_IDLE) || w_frame_end);
    assign w_accept    = DATA_VALID && r_ready && !w_load;

    assign DATA_READY  = r_ready;
    assign TX_OUT      = r_tx;
    assign Busy        = r_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_data    <= '0;
            r_buf_par_en  <= 1'b0;
            r_buf_par_typ <= 1'b0;
            r_buf_full    <= 1'b0;
            r_ready       <= 1'b1;
        end else if (w_load) begin
            r_buf_full    <= 1'b0;
            r_ready       <= 1'b1;
        end else if (w_accept) begin
            r_buf_data    <= P_DATA;
            r_buf_par_en  <= PAR_EN;
            r_buf_par_typ <= PAR_TYP;
            r_buf_full    <= 1'b1;
            r_ready       <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else if (w_load) begin
            r_state   <= S_START;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= r_buf_data;
            r_par_en  <= r_buf_par_en;
            r_par_bit <= (^r_buf_data) ^ r_buf_par_typ;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
        end else if (r_state == S_IDLE) begin
            r_cnt     <= '0;
            r_idx     <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_cnt <= w_bit_end ? '0 : r_cnt + 1'b1;
            if (w_bit_end) begin
                case (r_state)
                    S_START: begin
                        r_state <= S_DATA;
                        r_idx   <= '0;
                        r_tx    <= r_shift[0];
                    end
                    S_DATA: begin
                        if (r_idx == c_data_last) begin
                            r_idx <= '0;
                            if (r_par_en) begin
                                r_state <= S_PARITY;
                                r_tx    <= r_par_bit;
                            end else begin
                                r_state <= S_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end
                    S_PARITY: begin
                        r_state <= S_STOP;
                        r_idx   <= '0;
                        r_tx    <= 1'b1;
                    end
                    S_STOP: begin
                        if (r_idx == c_stop_last) begin
                            r_state <= S_IDLE;
                            r_idx   <= '0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                        end
                        r_tx <= 1'b1;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_param
// Brief    : Directed self-checking bench for uart_tx_param (default and
//            7-bit / 2-stop / 4-clock configurations).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic [7:0] p_data1  = '0;
    logic       valid1   = 1'b0;
    logic       par_en1  = 1'b0;
    logic       par_typ1 = 1'b0;
    logic       ready1;
    logic       tx1;
    logic       busy1;

    logic [6:0] p_data2  = '0;
    logic       valid2   = 1'b0;
    logic       par_en2  = 1'b0;
    logic       par_typ2 = 1'b0;
    logic       ready2;
    logic       tx2;
    logic       busy2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_param u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (p_data1),
        .DATA_VALID (valid1),
        .DATA_READY (ready1),
        .PAR_EN     (par_en1),
        .PAR_TYP    (par_typ1),
        .TX_OUT     (tx1),
        .Busy       (busy1)
    );

    uart_tx_param #(
        .DATA_WIDTH   (7),
        .CLKS_PER_BIT (4),
        .STOP_BITS    (2)
    ) u_dut2 (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (p_data2),
        .DATA_VALID (valid2),
        .DATA_READY (ready2),
        .PAR_EN     (par_en2),
        .PAR_TYP    (par_typ2),
        .TX_OUT     (tx2),
        .Busy       (busy2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic tx_of(input int sel);
        return (sel != 0) ? tx2 : tx1;
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel != 0) ? busy2 : busy1;
    endfunction

    function automatic logic ready_of(input int sel);
        return (sel != 0) ? ready2 : ready1;
    endfunction

    task automatic drive(input int sel, input logic [8:0] data, input logic pen,
                         input logic ptyp, input logic v);
        if (sel != 0) begin
            p_data2  = data[6:0];
            par_en2  = pen;
            par_typ2 = ptyp;
            valid2   = v;
        end else begin
            p_data1  = data[7:0];
            par_en1  = pen;
            par_typ1 = ptyp;
            valid1   = v;
        end
    endtask

    // Called on a falling edge; holds VALID until a rising edge sees READY, then
    // scrambles the inputs so a late capture would corrupt the frame.
    task automatic send(input int sel, input logic [8:0] data, input logic pen,
                        input logic ptyp, input string tag);
        int  t;
        bit  done;
        t    = 0;
        done = 1'b0;
        drive(sel, data, pen, ptyp, 1'b1);
        while (!done && t < 1000) begin
            if (ready_of(sel) === 1'b1) done = 1'b1;
            @(negedge clk);
            t++;
        end
        drive(sel, ~data, ~pen, ~ptyp, 1'b0);
        check({tag, "_accepted"}, 32'(done), 32'd1);
    endtask

    // Waits for a start bit, then checks every cycle of every bit of the frame.
    task automatic expect_frame(input int sel, input logic [15:0] frame, input int nbits,
                                input int cpb, input string tag, output int gap);
        logic [31:0] s;
        logic [31:0] mask;
        int          busy_cnt;
        busy_cnt = 0;
        gap      = 0;
        while (tx_of(sel) !== 1'b0 && gap < 1000) begin
            @(negedge clk);
            gap++;
        end
        check({tag, "_start_seen"}, 32'(tx_of(sel) === 1'b0), 32'd1);
        if (tx_of(sel) !== 1'b0) return;
        mask = (32'd1 << cpb) - 32'd1;
        for (int b = 0; b < nbits; b++) begin
            s = '0;
            for (int c = 0; c < cpb; c++) begin
                s[c] = tx_of(sel);
                if (busy_of(sel) === 1'b1) busy_cnt++;
                @(negedge clk);
            end
            check($sformatf("%s_bit%0d", tag, b), s, frame[b] ? mask : 32'd0);
        end
        check({tag, "_busy_len"}, 32'(busy_cnt), 32'(nbits * cpb));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int gap;
        gap = 0;
        #1 rst = 1'b1;
        #1;
        check("rst_tx1",    32'(tx1),    32'd1);
        check("rst_busy1",  32'(busy1),  32'd0);
        check("rst_ready1", 32'(ready1), 32'd1);
        check("rst_tx2",    32'(tx2),    32'd1);
        check("rst_ready2", 32'(ready2), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 0xA5, no parity: start, 1,0,1,0,0,1,0,1, stop
        fork
            send(0, 9'h0A5, 1'b0, 1'b0, "a5");
            expect_frame(0, 16'h034A, 10, 16, "a5", gap);
        join
        check("a5_end_busy", 32'(busy1), 32'd0);
        check("a5_end_tx",   32'(tx1),   32'd1);

        // 0x07 even parity -> 1, odd parity -> 0
        fork
            send(0, 9'h007, 1'b1, 1'b0, "p07e");
            expect_frame(0, 16'h060E, 11, 16, "p07e", gap);
        join
        fork
            send(0, 9'h007, 1'b1, 1'b1, "p07o");
            expect_frame(0, 16'h040E, 11, 16, "p07o", gap);
        join
        check("p07_end_busy", 32'(busy1), 32'd0);

        // Back-to-back words, third one held while the buffer is full
        fork
            begin
                send(0, 9'h011, 1'b0, 1'b0, "w11");
                send(0, 9'h022, 1'b0, 1'b0, "w22");
                check("ready_low_full", 32'(ready1), 32'd0);
                send(0, 9'h033, 1'b0, 1'b0, "w33");
            end
            begin
                expect_frame(0, 16'h0222, 10, 16, "f11", gap);
                expect_frame(0, 16'h0244, 10, 16, "f22", gap);
                check("gap_11_22", 32'(gap), 32'd0);
                expect_frame(0, 16'h0266, 10, 16, "f33", gap);
                check("gap_22_33", 32'(gap), 32'd0);
            end
        join
        check("b2b_end_busy", 32'(busy1), 32'd0);

        // Reset in the middle of data bit 0 with a second word buffered
        send(0, 9'h05A, 1'b0, 1'b0, "r5a");
        send(0, 9'h03C, 1'b0, 1'b0, "r3c");
        repeat (20) @(negedge clk);
        check("pre_rst_tx",    32'(tx1),    32'd0);
        check("pre_rst_busy",  32'(busy1),  32'd1);
        check("pre_rst_ready", 32'(ready1), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_tx",    32'(tx1),    32'd1);
        check("mid_rst_busy",  32'(busy1),  32'd0);
        check("mid_rst_ready", 32'(ready1), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        fork
            begin
                send(0, 9'h0C3, 1'b0, 1'b0, "c3");
                check("first_edge_accept", 32'(ready1), 32'd0);
            end
            expect_frame(0, 16'h0386, 10, 16, "c3", gap);
        join
        check("c3_end_busy", 32'(busy1), 32'd0);

        // 7 data bits, even parity of 0x55 -> 0, two stop bits, 4 clocks per bit
        fork
            send(1, 9'h055, 1'b1, 1'b0, "d2");
            expect_frame(1, 16'h06AA, 11, 4, "d2", gap);
        join
        check("d2_end_busy", 32'(busy2), 32'd0);
        check("d2_end_tx",   32'(tx2),   32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
